// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction formats,
// program-loader states and loader error codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} instr_fmt_e;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  // Classify an opcode into its encoding format; unknown opcodes are illegal.
  function automatic instr_fmt_e op_fmt(input logic [5:0] op);
    instr_fmt_e fmt;
    case (op)
      OP_RTYPE:                                          fmt = FMT_R;
      OP_LW, OP_SW, OP_LUI, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI: fmt = FMT_I;
      OP_J, OP_JAL:                                      fmt = FMT_J;
      default:                                           fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_fmt_enc.sv
// Combinational MIPS instruction packer: builds the 32-bit word for the
// format selected by the opcode and reports whether the opcode is supported.
module instr_fmt_enc
  import mips_pkg::*;
(
  input  logic [5:0]  op_i6,
  input  logic [4:0]  rs_i5,
  input  logic [4:0]  rt_i5,
  input  logic [4:0]  rd_i5,
  input  logic [4:0]  shamt_i5,
  input  logic [5:0]  funct_i6,
  input  logic [15:0] imm_i16,
  input  logic [25:0] target_i26,
  output logic [31:0] word_o32,
  output logic        legal_o
);

  instr_fmt_e fmt;

  // Pack only the fields that belong to the opcode's format; others are ignored.
  always_comb begin
    fmt      = op_fmt(op_i6);
    word_o32 = 32'h0000_0000;
    legal_o  = 1'b0;
    case (fmt)
      FMT_R: begin
        word_o32 = {op_i6, rs_i5, rt_i5, rd_i5, shamt_i5, funct_i6};
        legal_o  = 1'b1;
      end
      FMT_I: begin
        word_o32 = {op_i6, rs_i5, rt_i5, imm_i16};
        legal_o  = 1'b1;
      end
      FMT_J: begin
        word_o32 = {op_i6, target_i26};
        legal_o  = 1'b1;
      end
      default: begin
        word_o32 = 32'h0000_0000;
        legal_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader_enc.sv
// Program loader: accepts field-level instruction tuples, encodes them and
// writes them to instruction memory at sequential word addresses through a
// single pending-word register with valid/ready handshakes on both sides.
// Optional build macro ENC_NOP_PAD_EN: after the last word, fill the rest of
// the DEPTH-word region with zero words (sll $0,$0,0) before reporting done.
module instr_loader_enc
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [5:0]        op_i6,
  input  logic [4:0]        rs_i5,
  input  logic [4:0]        rt_i5,
  input  logic [4:0]        rd_i5,
  input  logic [4:0]        shamt_i5,
  input  logic [5:0]        funct_i6,
  input  logic [15:0]       imm_i16,
  input  logic [25:0]       target_i26,
  input  logic              last_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o32,
  input  logic              wr_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o2,
  output logic [ADDR_W:0]   count_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  loader_state_e     state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              pend_last_q, pend_last_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              wr_fire;
  logic              accept;
  logic              restart;
  logic              pend_room;
  logic              pad_load;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     count_plus_pend;

  instr_fmt_enc u_fmt_enc (
    .op_i6      (op_i6),
    .rs_i5      (rs_i5),
    .rt_i5      (rt_i5),
    .rd_i5      (rd_i5),
    .shamt_i5   (shamt_i5),
    .funct_i6   (funct_i6),
    .imm_i16    (imm_i16),
    .target_i26 (target_i26),
    .word_o32   (enc_word),
    .legal_o    (enc_legal)
  );

  // Decode this cycle's handshake events and the word count they lead to.
  always_comb begin
    wr_fire         = pend_valid_q && wr_ready_i;
    count_next      = wr_fire ? (count_q + CW'(1)) : count_q;
    count_plus_pend = count_q + CW'(pend_valid_q);
    pend_room       = !pend_valid_q || wr_ready_i;
    accept          = in_valid_i && in_ready_o;
    restart         = start_i && (state_q inside {IDLE, DONE, ERR});
`ifdef ENC_NOP_PAD_EN
    pad_load = ((state_q == PAD) || (state_q == LOAD && wr_fire && pend_last_q))
               && pend_room && (count_next < DEPTH_C);
`else
    pad_load = 1'b0;
`endif
  end

  // Output decode; a pending last word or any error stops further accepts.
  always_comb begin
    in_ready_o  = (state_q == LOAD) && (err_q == ERR_NONE)
                  && !(pend_valid_q && pend_last_q) && pend_room
                  && (count_plus_pend < DEPTH_C);
    busy_o      = (state_q == LOAD);
    done_o      = (state_q == DONE);
    wr_en_o     = pend_valid_q;
    wr_addr_o   = pend_addr_q;
    wr_data_o32 = pend_data_q;
    err_o2      = err_q;
    count_o     = count_q;
  end

  // Next-state logic: errors wait for an in-flight write before leaving LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (wr_fire && pend_last_q) begin
`ifdef ENC_NOP_PAD_EN
          state_d = (count_next < DEPTH_C) ? PAD : DONE;
`else
          state_d = DONE;
`endif
        end else if ((err_q == ERR_ILL || (accept && !enc_legal))
                     && !(pend_valid_q && !wr_fire)) begin
          state_d = ERR;
        end else if (wr_fire && count_next == DEPTH_C) begin
          state_d = ERR;
        end
      end
      PAD: begin
        if (pend_room && count_next >= DEPTH_C) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-word, counter and error bookkeeping.
  always_comb begin
    pend_valid_d = pend_valid_q && !wr_fire;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    pend_addr_d  = pend_addr_q;
    count_d      = count_next;
    err_d        = err_q;
    if (restart) begin
      pend_valid_d = 1'b0;
      count_d      = '0;
      err_d        = ERR_NONE;
    end else begin
      if (accept) begin
        if (enc_legal) begin
          pend_valid_d = 1'b1;
          pend_data_d  = enc_word;
          pend_last_d  = last_i;
          pend_addr_d  = BASE_C + count_next[ADDR_W-1:0];
        end else begin
          err_d = ERR_ILL;
        end
      end
      if (pad_load) begin
        pend_valid_d = 1'b1;
        pend_data_d  = 32'h0000_0000;
        pend_last_d  = 1'b0;
        pend_addr_d  = BASE_C + count_next[ADDR_W-1:0];
      end
      if (state_q == LOAD && wr_fire && !pend_last_q
          && count_next == DEPTH_C && err_q == ERR_NONE) begin
        err_d = ERR_OVF;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers; reset drops any pending word without writing it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= 32'h0000_0000;
      pend_last_q  <= 1'b0;
      pend_addr_q  <= '0;
      count_q      <= '0;
      err_q        <= ERR_NONE;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_last_q  <= pend_last_d;
      pend_addr_q  <= pend_addr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_loader_enc.sv
// Bench for instr_loader_enc: table-driven encoder vectors plus directed
// sequences for streaming, backpressure, illegal ops, overflow and reset.
module tb_instr_loader_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, sh = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] tgt = '0;
  logic        last = 1'b0;
  logic        wr_ready = 1'b1;

  logic        ready_a, wren_a, busy_a, done_a;
  logic [5:0]  addr_a;
  logic [31:0] data_a;
  logic [1:0]  err_a;
  logic [6:0]  count_a;

  logic        ready_b, wren_b, busy_b, done_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [1:0]  err_b;
  logic [2:0]  count_b;

  logic [31:0] log_a_data[$];
  logic [5:0]  log_a_addr[$];
  logic [31:0] log_b_data[$];
  logic [1:0]  log_b_addr[$];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  instr_loader_enc #(.ADDR_W(6), .DEPTH(8), .BASE_ADDR(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(ready_a), .op_i6(op), .rs_i5(rs), .rt_i5(rt), .rd_i5(rd),
    .shamt_i5(sh), .funct_i6(funct), .imm_i16(imm), .target_i26(tgt),
    .last_i(last), .wr_en_o(wren_a), .wr_addr_o(addr_a), .wr_data_o32(data_a),
    .wr_ready_i(wr_ready), .busy_o(busy_a), .done_o(done_a), .err_o2(err_a),
    .count_o(count_a)
  );

  instr_loader_enc #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(ready_b), .op_i6(op), .rs_i5(rs), .rt_i5(rt), .rd_i5(rd),
    .shamt_i5(sh), .funct_i6(funct), .imm_i16(imm), .target_i26(tgt),
    .last_i(last), .wr_en_o(wren_b), .wr_addr_o(addr_b), .wr_data_o32(data_b),
    .wr_ready_i(wr_ready), .busy_o(busy_b), .done_o(done_b), .err_o2(err_b),
    .count_o(count_b)
  );

  // Record every completed memory write of both loaders.
  always @(posedge clk) begin
    if (!rst) begin
      if (wren_a && wr_ready) begin
        log_a_data.push_back(data_a);
        log_a_addr.push_back(addr_a);
      end
      if (wren_b && wr_ready) begin
        log_b_data.push_back(data_b);
        log_b_addr.push_back(addr_b);
      end
    end
  end

  function automatic vec_t mk(logic [5:0] o, logic [4:0] s, logic [4:0] t,
                              logic [4:0] d, logic [4:0] sa, logic [5:0] f,
                              logic [15:0] im, logic [25:0] tg, logic lg,
                              logic [31:0] w);
    vec_t v;
    v.op = o; v.rs = s; v.rt = t; v.rd = d; v.sh = sa; v.funct = f;
    v.imm = im; v.tgt = tg; v.legal = lg; v.word = w;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setFields(input vec_t v, input logic lastf);
    op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; sh = v.sh;
    funct = v.funct; imm = v.imm; tgt = v.tgt; last = lastf;
  endtask

  // Drive a tuple (called at a falling edge) and wait until it is accepted;
  // returns at the falling edge after the accepting clock edge.
  task automatic applyStimulus(input vec_t v, input logic lastf, input int which);
    logic ok;
    ok = 1'b0;
    setFields(v, lastf);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((which == 0) ? ready_a : ready_b) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    checkOutput("accept", 32'(ok), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    log_a_data.delete(); log_a_addr.delete();
    log_b_data.delete(); log_b_addr.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int exp_n;
    vecs[0]  = mk(6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 16'h0000, 26'h0, 1'b1, 32'h0022_1820);
    vecs[1]  = mk(6'h23, 5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 16'h0004, 26'h0, 1'b1, 32'h8FA8_0004);
    vecs[2]  = mk(6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h10, 1'b1, 32'h0800_0010);
    vecs[3]  = mk(6'h2B, 5'd2,  5'd5,  5'd0,  5'd0, 6'h00, 16'hFFFC, 26'h0, 1'b1, 32'hAC45_FFFC);
    vecs[4]  = mk(6'h0F, 5'd0,  5'd1,  5'd31, 5'd7, 6'h3F, 16'h1234, 26'h0, 1'b1, 32'h3C01_1234);
    vecs[5]  = mk(6'h04, 5'd4,  5'd5,  5'd0,  5'd0, 6'h00, 16'h0003, 26'h0, 1'b1, 32'h1085_0003);
    vecs[6]  = mk(6'h05, 5'd6,  5'd7,  5'd0,  5'd0, 6'h00, 16'h8000, 26'h0, 1'b1, 32'h14C7_8000);
    vecs[7]  = mk(6'h03, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFF_FFFF);
    vecs[8]  = mk(6'h08, 5'd1,  5'd1,  5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b1, 32'h2021_FFFF);
    vecs[9]  = mk(6'h0A, 5'd3,  5'd9,  5'd0,  5'd0, 6'h00, 16'h000A, 26'h0, 1'b1, 32'h2869_000A);
    vecs[10] = mk(6'h00, 5'd0,  5'd0,  5'd8,  5'd4, 6'h00, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0000_4100);
    vecs[11] = mk(6'h3F, 5'd1,  5'd2,  5'd3,  5'd0, 6'h00, 16'h0000, 26'h0, 1'b0, 32'h0);
    vecs[12] = mk(6'h01, 5'd1,  5'd2,  5'd3,  5'd0, 6'h00, 16'h0000, 26'h0, 1'b0, 32'h0);

    // Reset state of both loaders.
    @(negedge clk);
    checkOutput("rst_ready_a", 32'(ready_a), 32'd0);
    checkOutput("rst_wren_a",  32'(wren_a),  32'd0);
    checkOutput("rst_addr_a",  32'(addr_a),  32'd0);
    checkOutput("rst_data_a",  data_a,       32'd0);
    checkOutput("rst_busy_a",  32'(busy_a),  32'd0);
    checkOutput("rst_done_a",  32'(done_a),  32'd0);
    checkOutput("rst_err_a",   32'(err_a),   32'd0);
    checkOutput("rst_count_a", 32'(count_a), 32'd0);
    checkOutput("rst_wren_b",  32'(wren_b),  32'd0);
    checkOutput("rst_count_b", 32'(count_b), 32'd0);
    rst = 1'b0;

    // Encoder table: one-word programs, first write (or error) checked.
    for (int i = 0; i < 13; i++) begin
      doReset();
      pulseStart();
      applyStimulus(vecs[i], 1'b1, 0);
      in_valid = 1'b0;
      #1;
      if (vecs[i].legal) begin
        checkOutput($sformatf("vec%0d_wren", i), 32'(wren_a), 32'd1);
        checkOutput($sformatf("vec%0d_data", i), data_a, vecs[i].word);
        checkOutput($sformatf("vec%0d_addr", i), 32'(addr_a), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d_wren", i), 32'(wren_a), 32'd0);
        checkOutput($sformatf("vec%0d_err", i), 32'(err_a), 32'd1);
      end
    end

    // Three-word program: start+valid in IDLE, start ignored in LOAD.
    doReset();
    setFields(vecs[0], 1'b0);
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    checkOutput("s1_idle_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    start = 1'b0;
    applyStimulus(vecs[0], 1'b0, 0);
    #1;
    checkOutput("s1_wren", 32'(wren_a), 32'd1);
    checkOutput("s1_addr0", 32'(addr_a), 32'd0);
    checkOutput("s1_data0", data_a, 32'h0022_1820);
    checkOutput("s1_busy", 32'(busy_a), 32'd1);
    start = 1'b1;
    applyStimulus(vecs[1], 1'b0, 0);
    start = 1'b0;
    applyStimulus(vecs[2], 1'b1, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_a) break;
      @(negedge clk);
    end
    checkOutput("s1_done", 32'(done_a), 32'd1);
`ifdef ENC_NOP_PAD_EN
    exp_n = 8;
`else
    exp_n = 3;
`endif
    checkOutput("s1_count", 32'(count_a), 32'(exp_n));
    checkOutput("s1_nwrites", 32'(log_a_data.size()), 32'(exp_n));
    for (int k = 0; k < exp_n; k++) begin
      if (log_a_data.size() > k) begin
        checkOutput($sformatf("s1_addr%0d", k), 32'(log_a_addr[k]), 32'(k));
        checkOutput($sformatf("s1_data%0d", k), log_a_data[k],
                    (k < 3) ? vecs[k].word : 32'h0);
      end
    end

    // Backpressure: pending word holds, second tuple waits, then streams.
    doReset();
    pulseStart();
    wr_ready = 1'b0;
    applyStimulus(vecs[0], 1'b0, 0);
    setFields(vecs[1], 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_wren", 32'(wren_a), 32'd1);
      checkOutput("bp_data", data_a, 32'h0022_1820);
      checkOutput("bp_addr", 32'(addr_a), 32'd0);
      checkOutput("bp_ready", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    checkOutput("bp_nwrites0", 32'(log_a_data.size()), 32'd0);
    wr_ready = 1'b1;
    #1;
    checkOutput("bp_ready_rel", 32'(ready_a), 32'd1);
    @(negedge clk);
    checkOutput("bp_nwrites1", 32'(log_a_data.size()), 32'd1);
    checkOutput("bp_data1", data_a, 32'h8FA8_0004);
    checkOutput("bp_addr1", 32'(addr_a), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_nwrites2", 32'(log_a_data.size()), 32'd2);
    checkOutput("bp_count", 32'(count_a), 32'd2);
    checkOutput("bp_wren_end", 32'(wren_a), 32'd0);

    // Illegal opcode: ERR, no accepts until start clears the error.
    doReset();
    pulseStart();
    applyStimulus(vecs[11], 1'b0, 0);
    checkOutput("ill_err", 32'(err_a), 32'd1);
    checkOutput("ill_busy", 32'(busy_a), 32'd0);
    checkOutput("ill_wren", 32'(wren_a), 32'd0);
    setFields(vecs[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("ill_ready", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    checkOutput("ill_nwrites", 32'(log_a_data.size()), 32'd0);
    checkOutput("ill_err_sticky", 32'(err_a), 32'd1);
    in_valid = 1'b0;
    pulseStart();
    checkOutput("ill_err_clr", 32'(err_a), 32'd0);
    checkOutput("ill_busy_again", 32'(busy_a), 32'd1);

    // Overflow on the DEPTH=4 loader at base 2 (addresses wrap 2,3,0,1).
    doReset();
    pulseStart();
    for (int k = 0; k < 4; k++) applyStimulus(vecs[3 + k], 1'b0, 1);
    setFields(vecs[7], 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("ovf_ready", 32'(ready_b), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("ovf_err", 32'(err_b), 32'd2);
    checkOutput("ovf_count", 32'(count_b), 32'd4);
    checkOutput("ovf_busy", 32'(busy_b), 32'd0);
    checkOutput("ovf_nwrites", 32'(log_b_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (log_b_data.size() > k) begin
        checkOutput($sformatf("ovf_addr%0d", k), 32'(log_b_addr[k]), 32'((k + 2) % 4));
        checkOutput($sformatf("ovf_data%0d", k), log_b_data[k], vecs[3 + k].word);
      end
    end

    // Reset while a write is stalled drops the pending word.
    doReset();
    pulseStart();
    wr_ready = 1'b0;
    applyStimulus(vecs[0], 1'b0, 0);
    in_valid = 1'b0;
    #1;
    checkOutput("mid_wren_pre", 32'(wren_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_wren", 32'(wren_a), 32'd0);
    checkOutput("mid_count", 32'(count_a), 32'd0);
    checkOutput("mid_busy", 32'(busy_a), 32'd0);
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mid_nwrites", 32'(log_a_data.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
